// File: rtl/vxc_pkg.sv
// Shared types and arithmetic helpers for the vXc multiply-add stream engine.
package vxc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } vxc_state_e;

  // Clamp a sign-extended value to the signed range of a w-bit word (w <= 63).
  function automatic logic signed [127:0] sat_fx(input logic signed [127:0] s, input int w);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

  function automatic logic [31:0] ceil_div(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] t;
    t = {1'b0, a} + {1'b0, b} - 33'd1;
    return 32'(t / {1'b0, b});
  endfunction

endpackage

// File: rtl/vxc_lane.sv
// One lane: first +/- (constant*second >>> FRAC), saturated, delayed LAT cycles.
module vxc_lane
  import vxc_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int LAT  = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_op,
  input  logic [W-1:0] i_constant,
  input  logic [W-1:0] i_first,
  input  logic [W-1:0] i_second,
  output logic [W-1:0] o_result
);

  logic signed [2*W-1:0] w_c_x;
  logic signed [2*W-1:0] w_s_x;
  logic signed [2*W-1:0] w_prod;
  logic signed [2*W-1:0] w_shift;
  logic signed [2*W:0]   w_first_x;
  logic signed [2*W:0]   w_shift_x;
  logic signed [2*W:0]   w_sum;
  logic signed [127:0]   w_sum_x;
  logic        [W-1:0]   w_res;
  logic        [W-1:0]   r_pipe [LAT];

  assign w_c_x     = {{W{i_constant[W-1]}}, i_constant};
  assign w_s_x     = {{W{i_second[W-1]}}, i_second};
  assign w_prod    = w_c_x * w_s_x;
  assign w_shift   = w_prod >>> FRAC;
  assign w_first_x = {{(W+1){i_first[W-1]}}, i_first};
  assign w_shift_x = {w_shift[2*W-1], w_shift};
  assign w_sum     = i_op ? (w_first_x - w_shift_x) : (w_first_x + w_shift_x);
  assign w_sum_x   = {{(127-2*W){w_sum[2*W]}}, w_sum};
  assign w_res     = W'(sat_fx(w_sum_x, W));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_res;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_result = r_pipe[LAT-1];

endmodule

// File: rtl/vxc_axpy_stream.sv
// Streaming result = first +/- constant*second engine with credit-limited reads and tail masking.
module vxc_axpy_stream
  import vxc_pkg::*;
#(
  parameter int W       = 32,
  parameter int FRAC    = 16,
  parameter int NI      = 8,
  parameter int LAT     = 3,
  parameter int MAX_OUT = 4,
  parameter int AW      = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [31:0]     i_total,
  input  logic [W-1:0]    i_constant,
  input  logic            i_op,
  output logic            o_rd_req,
  output logic [AW-1:0]   o_rd_addr,
  input  logic            i_rd_valid,
  input  logic [W*NI-1:0] i_first_row,
  input  logic [W*NI-1:0] i_second_row,
  output logic [W*NI-1:0] o_result,
  output logic            o_wr_en,
  output logic [AW-1:0]   o_wr_addr,
  output logic [NI-1:0]   o_wr_mask,
  output logic            o_busy,
  output logic            o_finish
);

  localparam int CW = $clog2(MAX_OUT + 1);

  vxc_state_e    r_state, w_next;
  logic [31:0]   r_nbeats, r_rem, r_issued, r_ret, r_written;
  logic [CW-1:0] r_outst;
  logic [W-1:0]  r_const;
  logic          r_op;
  logic          w_issue, w_accept, w_wr, w_all_written;
  logic [NI-1:0] w_mask_in;
  logic          r_v [LAT];
  logic [AW-1:0] r_a [LAT];
  logic [NI-1:0] r_m [LAT];
  logic [W-1:0]  w_lane_res [NI];

  assign w_issue  = (r_state == ST_RUN) && (r_outst < CW'(MAX_OUT)) && (r_issued < r_nbeats);
  // A same-cycle return against the request being issued is still a matched return.
  assign w_accept = i_rd_valid && ((r_outst != '0) || w_issue);
  assign w_wr     = r_v[LAT-1];
  assign w_all_written = (r_written == r_nbeats) ||
                         (w_wr && ((r_written + 32'd1) == r_nbeats));

  always_comb begin
    w_mask_in = '1;
    if ((r_ret == (r_nbeats - 32'd1)) && (r_rem != 32'd0)) begin
      for (int i = 0; i < NI; i++) w_mask_in[i] = (32'(i) < r_rem);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = (i_total == 32'd0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (r_issued == r_nbeats) w_next = ST_DRAIN;
      ST_DRAIN: if (w_all_written) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_nbeats  <= '0;
      r_rem     <= '0;
      r_const   <= '0;
      r_op      <= 1'b0;
      r_issued  <= '0;
      r_ret     <= '0;
      r_written <= '0;
      r_outst   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && i_start) begin
        r_nbeats  <= ceil_div(i_total, 32'(NI));
        r_rem     <= i_total % 32'(NI);
        r_const   <= i_constant;
        r_op      <= i_op;
        r_issued  <= '0;
        r_ret     <= '0;
        r_written <= '0;
        r_outst   <= '0;
      end else begin
        if (w_issue)  r_issued  <= r_issued + 32'd1;
        if (w_accept) r_ret     <= r_ret + 32'd1;
        if (w_wr)     r_written <= r_written + 32'd1;
        if (w_issue && !w_accept)      r_outst <= r_outst + CW'(1);
        else if (!w_issue && w_accept) r_outst <= r_outst - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < LAT; i++) begin
        r_v[i] <= 1'b0;
        r_a[i] <= '0;
        r_m[i] <= '0;
      end
    end else begin
      r_v[0] <= w_accept;
      r_a[0] <= r_ret[AW-1:0];
      r_m[0] <= w_mask_in;
      for (int i = 1; i < LAT; i++) begin
        r_v[i] <= r_v[i-1];
        r_a[i] <= r_a[i-1];
        r_m[i] <= r_m[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) assert (!(i_rd_valid && !w_accept));
  end

  for (genvar g = 0; g < NI; g++) begin : g_lane
    vxc_lane #(.W(W), .FRAC(FRAC), .LAT(LAT)) u_lane (
      .i_clk      (i_clk),
      .i_rst_n    (i_reset),
      .i_op       (r_op),
      .i_constant (r_const),
      .i_first    (i_first_row[g*W +: W]),
      .i_second   (i_second_row[g*W +: W]),
      .o_result   (w_lane_res[g])
    );
    assign o_result[g*W +: W] = r_m[LAT-1][g] ? w_lane_res[g] : '0;
  end

  assign o_rd_req  = w_issue;
  assign o_rd_addr = r_issued[AW-1:0];
  assign o_wr_en   = w_wr;
  assign o_wr_addr = r_a[LAT-1];
  assign o_wr_mask = r_m[LAT-1];
  assign o_busy    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_finish  = (r_state == ST_DONE);

endmodule

// File: tb/tb_vxc_axpy_stream.sv
// Directed bench for vxc_axpy_stream with a latency-configurable row memory model.
module tb_vxc_axpy_stream;

  localparam int W = 32, FRAC = 16, NI = 8, LAT = 3, MAX_OUT = 4, AW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [31:0]     total = '0;
  logic [W-1:0]    constant = '0;
  logic            op = 1'b0;
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic            rd_valid = 1'b0;
  logic [W*NI-1:0] first_row = '0;
  logic [W*NI-1:0] second_row = '0;
  logic [W*NI-1:0] result;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [NI-1:0]   wr_mask;
  logic            busy;
  logic            finish;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int mem_lat = 2;
  int q_due[$];
  int rq_n, rv_n, wr_n, fin_n, max_out_seen;
  int rd_addr_log [64];
  int rv_cyc_log  [64];
  int wr_cyc_log  [64];
  logic [AW-1:0]   wr_addr_log [64];
  logic [NI-1:0]   wr_mask_log [64];
  logic [W*NI-1:0] wr_res_log  [64];

  vxc_axpy_stream #(.W(W), .FRAC(FRAC), .NI(NI), .LAT(LAT), .MAX_OUT(MAX_OUT), .AW(AW)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_total(total), .i_constant(constant),
    .i_op(op), .o_rd_req(rd_req), .o_rd_addr(rd_addr), .i_rd_valid(rd_valid),
    .i_first_row(first_row), .i_second_row(second_row), .o_result(result), .o_wr_en(wr_en),
    .o_wr_addr(wr_addr), .o_wr_mask(wr_mask), .o_busy(busy), .o_finish(finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Row memory: requests seen in cycle n return (in order) during cycle n+mem_lat.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_due.delete();
      rd_valid = 1'b0;
    end else begin
      if (rd_req) begin
        q_due.push_back(cyc + mem_lat);
        if (rq_n < 64) rd_addr_log[rq_n] = int'(rd_addr);
        rq_n++;
        if (q_due.size() > max_out_seen) max_out_seen = q_due.size();
      end
      rd_valid = 1'b0;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        rd_valid = 1'b1;
        if (rv_n < 64) rv_cyc_log[rv_n] = cyc;
        rv_n++;
        void'(q_due.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (wr_n < 64) begin
          wr_addr_log[wr_n] = wr_addr;
          wr_mask_log[wr_n] = wr_mask;
          wr_res_log[wr_n]  = result;
          wr_cyc_log[wr_n]  = cyc;
        end
        wr_n++;
      end
      if (finish) fin_n++;
    end
  end

  task automatic clear_logs();
    rq_n = 0; rv_n = 0; wr_n = 0; fin_n = 0; max_out_seen = 0;
  endtask

  task automatic set_lanes(input logic [W-1:0] f, input logic [W-1:0] s);
    for (int i = 0; i < NI; i++) begin
      first_row[i*W +: W]  = f;
      second_row[i*W +: W] = s;
    end
  endtask

  task automatic start_op(input int t, input logic [W-1:0] c, input logic o);
    @(negedge clk);
    start = 1'b1; total = t; constant = c; op = o;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (finish) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    checks++;
    if ({rd_req, rd_addr, wr_en, wr_addr, wr_mask, busy, finish} !== '0) begin
      errors++; $display("FAIL reset_ctrl got %h want 0", {rd_req, rd_addr, wr_en, wr_addr, wr_mask, busy, finish});
    end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [W*NI-1:0] exp;
    for (int i = 0; i < NI; i++) exp[i*W +: W] = 32'h0002_0000;
    mem_lat = 2; clear_logs(); set_lanes(32'h0001_0000, 32'h0000_8000);
    start_op(16, 32'h0002_0000, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_finish(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout finish got 0 want 1"); end
    @(negedge clk);
    checks++;
    if (wr_n !== 2 || fin_n !== 1 || rq_n !== 2) begin
      errors++; $display("FAIL basic_counts writes=%0d finishes=%0d reqs=%0d want 2 1 2", wr_n, fin_n, rq_n);
    end
    checks++;
    if (rd_addr_log[0] !== 0 || rd_addr_log[1] !== 1) begin
      errors++; $display("FAIL basic_rdaddr got %0d,%0d want 0,1", rd_addr_log[0], rd_addr_log[1]);
    end
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (wr_addr_log[b] !== AW'(b) || wr_mask_log[b] !== 8'hFF || wr_res_log[b] !== exp) begin
        errors++; $display("FAIL basic_beat%0d addr=%0d mask=%h res=%h want addr %0d mask ff res %h",
                           b, wr_addr_log[b], wr_mask_log[b], wr_res_log[b], b, exp);
      end
    end
    checks++;
    if (wr_cyc_log[0] - rv_cyc_log[0] !== LAT) begin
      errors++; $display("FAIL basic_latency got %0d want %0d", wr_cyc_log[0] - rv_cyc_log[0], LAT);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_tail();
    bit ok;
    logic [W*NI-1:0] exp;
    for (int i = 0; i < NI; i++) exp[i*W +: W] = (i < 5) ? 32'h0002_0000 : 32'h0;
    mem_lat = 2; clear_logs(); set_lanes(32'h0001_0000, 32'h0000_8000);
    start_op(13, 32'h0002_0000, 1'b0);
    wait_finish(200, ok);
    @(negedge clk);
    checks++;
    if (!ok || wr_n !== 2) begin errors++; $display("FAIL tail_count finish=%b writes=%0d want 1 2", ok, wr_n); end
    checks++;
    if (wr_mask_log[0] !== 8'hFF || wr_mask_log[1] !== 8'h1F) begin
      errors++; $display("FAIL tail_mask got %h,%h want ff,1f", wr_mask_log[0], wr_mask_log[1]);
    end
    checks++;
    if (wr_res_log[1] !== exp) begin errors++; $display("FAIL tail_result got %h want %h", wr_res_log[1], exp); end
  endtask

  task automatic test_zero();
    clear_logs();
    start_op(0, 32'h0002_0000, 1'b0);
    checks++;
    if (finish !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_finish finish=%b busy=%b want 1 0", finish, busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rq_n !== 0 || wr_n !== 0 || fin_n !== 1) begin
      errors++; $display("FAIL zero_traffic reqs=%0d writes=%0d finishes=%0d want 0 0 1", rq_n, wr_n, fin_n);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    logic [W*NI-1:0] exp;
    mem_lat = 1;
    clear_logs(); set_lanes(32'h8300_0000, 32'h000A_0000);
    start_op(8, 32'h0064_0000, 1'b1);
    wait_finish(100, ok);
    for (int i = 0; i < NI; i++) exp[i*W +: W] = 32'h8000_0000;
    checks++;
    if (!ok || wr_res_log[0] !== exp) begin errors++; $display("FAIL sat_min got %h want %h", wr_res_log[0], exp); end
    @(negedge clk);
    clear_logs(); set_lanes(32'h7D00_0000, 32'h000A_0000);
    start_op(8, 32'h0064_0000, 1'b0);
    wait_finish(100, ok);
    for (int i = 0; i < NI; i++) exp[i*W +: W] = 32'h7FFF_FFFF;
    checks++;
    if (!ok || wr_res_log[0] !== exp) begin errors++; $display("FAIL sat_max got %h want %h", wr_res_log[0], exp); end
    @(negedge clk);
    // c=0.5: -1 lsb -> -1 (floor), 3 lsb -> 1, 1.0 + 0.5*1.0 -> 1.5
    clear_logs(); set_lanes(32'h0001_0000, 32'h0001_0000);
    first_row[0 +: W] = 32'h0; second_row[0 +: W] = 32'hFFFF_FFFF;
    first_row[W +: W] = 32'h0; second_row[W +: W] = 32'h0000_0003;
    start_op(8, 32'h0000_8000, 1'b0);
    wait_finish(100, ok);
    for (int i = 0; i < NI; i++) exp[i*W +: W] = 32'h0001_8000;
    exp[0 +: W] = 32'hFFFF_FFFF;
    exp[W +: W] = 32'h0000_0001;
    checks++;
    if (!ok || wr_res_log[0] !== exp) begin errors++; $display("FAIL floor_shift got %h want %h", wr_res_log[0], exp); end
    @(negedge clk);
  endtask

  task automatic test_credits();
    bit ok;
    int bad;
    mem_lat = 6; clear_logs(); set_lanes(32'h0001_0000, 32'h0000_8000);
    start_op(80, 32'h0002_0000, 1'b0);
    wait_finish(400, ok);
    @(negedge clk);
    checks++;
    if (max_out_seen !== MAX_OUT) begin
      errors++; $display("FAIL credits_max outstanding got %0d want %0d", max_out_seen, MAX_OUT);
    end
    bad = 0;
    for (int b = 0; b < 10; b++) if (wr_addr_log[b] !== AW'(b)) bad++;
    checks++;
    if (!ok || wr_n !== 10 || bad !== 0) begin
      errors++; $display("FAIL credits_writes finish=%b writes=%0d bad_addr=%0d want 1 10 0", ok, wr_n, bad);
    end
  endtask

  task automatic test_throughput();
    bit ok;
    mem_lat = 1; clear_logs();
    start_op(80, 32'h0002_0000, 1'b0);
    wait_finish(200, ok);
    @(negedge clk);
    checks++;
    if (!ok || wr_n !== 10 || (wr_cyc_log[9] - wr_cyc_log[0]) !== 9) begin
      errors++; $display("FAIL throughput writes=%0d span=%0d want 10 9", wr_n, wr_cyc_log[9] - wr_cyc_log[0]);
    end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    mem_lat = 2; clear_logs();
    start_op(80, 32'h0002_0000, 1'b0);
    for (int k = 0; k < 200 && wr_n < 2; k++) @(negedge clk);
    checks++;
    if (wr_n < 2) begin errors++; $display("FAIL midrun_progress writes=%0d want >=2", wr_n); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_req, rd_addr, wr_en, wr_addr, wr_mask, busy, finish, result} !== '0) begin
      errors++; $display("FAIL midrun_reset outputs busy=%b wr_en=%b rd_req=%b result=%h want all 0",
                         busy, wr_en, rd_req, result);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    start_op(16, 32'h0002_0000, 1'b0);
    wait_finish(200, ok);
    @(negedge clk);
    checks++;
    if (!ok || wr_n !== 2 || wr_addr_log[0] !== 0 || rd_addr_log[0] !== 0 || fin_n !== 1) begin
      errors++; $display("FAIL midrun_restart writes=%0d wr0=%0d rd0=%0d fin=%0d want 2 0 0 1",
                         wr_n, wr_addr_log[0], rd_addr_log[0], fin_n);
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    mem_lat = 6; clear_logs();
    start_op(32, 32'h0002_0000, 1'b0);
    start_op(80, 32'h0002_0000, 1'b0);
    wait_finish(300, ok);
    checks++;
    if (!ok || wr_n !== 4) begin errors++; $display("FAIL busy_ignore finish=%b writes=%0d want 1 4", ok, wr_n); end
    start = 1'b1; total = 8;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_ignore busy got %b want 0", busy); end
    repeat (12) @(negedge clk);
    checks++;
    if (wr_n !== 4 || fin_n !== 1) begin
      errors++; $display("FAIL done_ignore_traffic writes=%0d finishes=%0d want 4 1", wr_n, fin_n);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    mem_lat = 1; clear_logs();
    start_op(8, 32'h0002_0000, 1'b0);
    wait_finish(100, ok1);
    @(negedge clk);
    start = 1'b1; total = 16;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b want 1", busy); end
    wait_finish(100, ok2);
    @(negedge clk);
    checks++;
    if (!ok1 || !ok2 || wr_n !== 3 || fin_n !== 2 || wr_addr_log[1] !== 0 || wr_addr_log[2] !== 1) begin
      errors++; $display("FAIL b2b_writes writes=%0d finishes=%0d addr1=%0d addr2=%0d want 3 2 0 1",
                         wr_n, fin_n, wr_addr_log[1], wr_addr_log[2]);
    end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_tail();
    test_zero();
    test_saturate();
    test_credits();
    test_throughput();
    test_reset_midrun();
    test_start_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
